flash_stream_writer: RTL and testbench

//  Upstream sequencer for flash_controller: takes a start address, a byte

---
 rtl/flash_stream_writer_pkg.sv | 20 ++
 rtl/flash_stream_writer_if.sv | 32 +++
 rtl/flash_stream_writer_op_waiter.sv | 38 +++
 rtl/flash_stream_writer.sv | 169 ++++++++++++++++
 tb/tb_flash_stream_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_stream_writer_pkg.sv
// rtl/flash_stream_writer_pkg.sv - shared constants and FSM state encoding for the stream writer
package flash_stream_writer_pkg;

  localparam int FLASH_AW      = 22;
  localparam int FLASH_TIMEOUT = 2 ** 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ERASE,
    ST_E_WAIT,
    ST_FETCH,
    ST_WRITE,
    ST_W_WAIT,
    ST_READ,
    ST_R_WAIT,
    ST_NEXT,
    ST_DONE
  } fsw_state_e;

endpackage

// File: rtl/flash_stream_writer_if.sv
// rtl/flash_stream_writer_if.sv - byte stream and flash_controller request bus
interface flash_stream_writer_if
  import flash_stream_writer_pkg::*;
#(
  parameter int AW = FLASH_AW
) ();

  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    fc_data_for_flash;
  logic [7:0]    fc_data_from_flash;
  logic [AW-1:0] fc_address;
  logic          fc_we;
  logic          fc_oe;
  logic          fc_erase;
  logic          fc_ready;
  logic          fc_error;

  // Writer side: consumes the stream, drives flash requests.
  modport master (
    input  s_data, s_valid, fc_data_from_flash, fc_ready, fc_error,
    output s_ready, fc_data_for_flash, fc_address, fc_we, fc_oe, fc_erase
  );

  // Environment side: stream source plus flash controller.
  modport slave (
    output s_data, s_valid, fc_data_from_flash, fc_ready, fc_error,
    input  s_ready, fc_data_for_flash, fc_address, fc_we, fc_oe, fc_erase
  );

endinterface

// File: rtl/flash_stream_writer_op_waiter.sv
// rtl/flash_stream_writer_op_waiter.sv - completion, error and timeout detect for one flash op
module flash_stream_writer_op_waiter
  import flash_stream_writer_pkg::*;
#(
  parameter int TIMEOUT = FLASH_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,       // request pulse visible on the bus this cycle
  input  logic wait_i,      // FSM is in one of the *_WAIT states
  input  logic fc_ready_i,
  input  logic fc_error_i,
  output logic complete_o,
  output logic error_o,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Count post-request wait cycles; every new request reloads the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (req_i) begin
      cnt_q <= '0;
    end else if (wait_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Guard: the request cycle still shows the idle ready, so it never completes an op.
  assign complete_o = wait_i & ~req_i & fc_ready_i;
  assign error_o    = complete_o & fc_error_i;
  assign timeout_o  = wait_i & ~req_i & ~fc_ready_i & (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/flash_stream_writer.sv
// rtl/flash_stream_writer.sv - programs a byte stream to consecutive flash addresses
module flash_stream_writer
  import flash_stream_writer_pkg::*;
#(
  parameter int VERIFY  = 1,
  parameter int TIMEOUT = FLASH_TIMEOUT,
  parameter int AW      = FLASH_AW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         start_addr_i,
  input  logic [AW:0]           length_i,
  input  logic                  do_erase_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [AW-1:0]         fail_addr_o,
  flash_stream_writer_if.master bus
);

  fsw_state_e    state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   rem_q;
  logic [7:0]    byte_q;
  logic          busy_q, done_q, fail_q;
  logic [AW-1:0] fail_addr_q;
  logic          s_ready_q, we_q, oe_q, erase_q;

  logic op_req, op_wait, op_done, op_err, op_timeout, rd_bad;

  assign op_req  = we_q | oe_q | erase_q;
  assign op_wait = (state_q == ST_E_WAIT) || (state_q == ST_W_WAIT) || (state_q == ST_R_WAIT);
  assign rd_bad  = op_done & (bus.fc_data_from_flash != byte_q);

  flash_stream_writer_op_waiter #(.TIMEOUT(TIMEOUT)) u_waiter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (op_req),
    .wait_i     (op_wait),
    .fc_ready_i (bus.fc_ready),
    .fc_error_i (bus.fc_error),
    .complete_o (op_done),
    .error_o    (op_err),
    .timeout_o  (op_timeout)
  );

  // Job sequencer: one byte in flight, each flash op waited to completion before the next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      byte_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      s_ready_q   <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      erase_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      erase_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            addr_q <= start_addr_i;
            rem_q  <= length_i;
            busy_q <= 1'b1;
            fail_q <= 1'b0;
            if (length_i == '0) begin
              state_q <= ST_DONE;
            end else if (do_erase_i) begin
              state_q <= ST_ERASE;
            end else begin
              state_q   <= ST_FETCH;
              s_ready_q <= 1'b1;
            end
          end
        end
        ST_ERASE: begin
          if (bus.fc_ready) begin
            erase_q <= 1'b1;
            state_q <= ST_E_WAIT;
          end
        end
        ST_E_WAIT: begin
          if (op_err || op_timeout) begin
            fail_q      <= 1'b1;
            fail_addr_q <= addr_q;
            state_q     <= ST_DONE;
          end else if (op_done) begin
            state_q   <= ST_FETCH;
            s_ready_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.s_valid) begin
            byte_q    <= bus.s_data;
            s_ready_q <= 1'b0;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.fc_ready) begin
            we_q    <= 1'b1;
            state_q <= ST_W_WAIT;
          end
        end
        ST_W_WAIT: begin
          if (op_err || op_timeout) begin
            fail_q      <= 1'b1;
            fail_addr_q <= addr_q;
            state_q     <= ST_DONE;
          end else if (op_done) begin
            state_q <= (VERIFY != 0) ? ST_READ : ST_NEXT;
          end
        end
        ST_READ: begin
          if (bus.fc_ready) begin
            oe_q    <= 1'b1;
            state_q <= ST_R_WAIT;
          end
        end
        ST_R_WAIT: begin
          if (op_err || op_timeout || rd_bad) begin
            fail_q      <= 1'b1;
            fail_addr_q <= addr_q;
            state_q     <= ST_DONE;
          end else if (op_done) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == (AW + 1)'(1)) begin
            state_q <= ST_DONE;
          end else begin
            state_q   <= ST_FETCH;
            s_ready_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign fail_o                = fail_q;
  assign fail_addr_o           = fail_addr_q;
  assign bus.s_ready           = s_ready_q;
  assign bus.fc_we             = we_q;
  assign bus.fc_oe             = oe_q;
  assign bus.fc_erase          = erase_q;
  assign bus.fc_address        = addr_q;
  assign bus.fc_data_for_flash = byte_q;

endmodule

// File: tb/tb_flash_stream_writer.sv
// tb/tb_flash_stream_writer.sv - self-checking bench with a behavioural flash controller
module tb_flash_stream_writer;

  localparam int AW  = 22;
  localparam int TMO = 16;
  localparam int N   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          do_erase = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;

  flash_stream_writer_if #(.AW(AW)) bus ();

  flash_stream_writer #(.VERIFY(1), .TIMEOUT(TMO), .AW(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .length_i     (length),
    .do_erase_i   (do_erase),
    .busy_o       (busy),
    .done_o       (done),
    .fail_o       (fail),
    .fail_addr_o  (fail_addr),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // controller model state
  int            m_rem = 0;
  bit            m_pending = 1'b0;
  int            m_kind = 0;           // 0 erase, 1 write, 2 read
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;
  logic [7:0]    mem [int];
  bit            hang = 1'b0;
  bit            eerr = 1'b0;
  int            corrupt = -1;
  int            rd_idx = 0;

  // stream source and expectations
  logic [7:0]    jb [$];
  logic [7:0]    src [$];
  bit            gap = 1'b0;
  int            consumed = 0;
  logic [AW-1:0] exp_we_a [$];
  logic [7:0]    exp_we_d [$];
  logic [AW-1:0] exp_oe_a [$];
  logic [AW-1:0] exp_er_a [$];
  bit            exp_fail = 1'b0;
  logic [AW-1:0] exp_fail_addr = '0;
  int            exp_consumed = 0;
  bit            job_active = 1'b0;

  // observations
  int            n_we = 0, n_oe = 0, n_er = 0, n_done = 0, n_sready = 0;
  int            we_cyc = 0, first_we_cyc = 0, er_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [AW-1:0] last_we_addr = '0, first_er_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_rem = 0;
      m_pending = 1'b0;
      bus.fc_ready = 1'b1;
      bus.fc_error = 1'b0;
      bus.fc_data_from_flash = 8'h00;
      bus.s_valid = 1'b0;
      bus.s_data = 8'h00;
    end else begin
      bus.fc_error = 1'b0;
      if (m_pending) begin
        m_pending = 1'b0;
        m_rem = N;
        bus.fc_ready = 1'b0;
      end else if (m_rem > 0 && !hang) begin
        m_rem--;
        if (m_rem == 0) begin
          bus.fc_ready = 1'b1;
          if (m_kind == 2) begin
            if (rd_idx == corrupt) bus.fc_data_from_flash = 8'h00;
            else if (mem.exists(int'(m_addr))) bus.fc_data_from_flash = mem[int'(m_addr)];
            else bus.fc_data_from_flash = 8'hFF;
            rd_idx++;
          end
          if (m_kind == 0 && eerr) bus.fc_error = 1'b1;
        end
      end
      if (m_rem > 0) begin
        chk("addr_stable", bus.fc_address, m_addr);
        if (m_kind == 1) chk("data_stable", bus.fc_data_for_flash, m_data);
      end
      if (bus.fc_we || bus.fc_oe || bus.fc_erase) begin
        chk("req_onehot", int'(bus.fc_we) + int'(bus.fc_oe) + int'(bus.fc_erase), 1);
        chk("req_when_ready", bus.fc_ready, 1'b1);
        m_pending = 1'b1;
        m_addr = bus.fc_address;
        m_data = bus.fc_data_for_flash;
        if (bus.fc_we) begin
          m_kind = 1;
          mem[int'(bus.fc_address)] = bus.fc_data_for_flash;
          if (n_we == 0) first_we_cyc = cyc;
          n_we++;
          we_cyc = cyc;
          last_we_addr = bus.fc_address;
          chk("we_expected", exp_we_a.size() > 0, 1'b1);
          if (exp_we_a.size() > 0) begin
            chk("we_addr", bus.fc_address, exp_we_a.pop_front());
            chk("we_data", bus.fc_data_for_flash, exp_we_d.pop_front());
          end
        end else if (bus.fc_oe) begin
          m_kind = 2;
          n_oe++;
          chk("oe_expected", exp_oe_a.size() > 0, 1'b1);
          if (exp_oe_a.size() > 0) chk("oe_addr", bus.fc_address, exp_oe_a.pop_front());
        end else begin
          m_kind = 0;
          if (n_er == 0) first_er_addr = bus.fc_address;
          n_er++;
          er_cyc = cyc;
          chk("erase_expected", exp_er_a.size() > 0, 1'b1);
          if (exp_er_a.size() > 0) chk("erase_addr", bus.fc_address, exp_er_a.pop_front());
        end
      end
      if (bus.s_ready) begin
        n_sready++;
        chk("s_ready_only_busy", busy, 1'b1);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk("done_in_job", job_active, 1'b1);
        job_active = 1'b0;
        chk("done_busy_low", busy, 1'b0);
        chk("done_fail", fail, exp_fail);
        if (exp_fail) chk("fail_addr", fail_addr, exp_fail_addr);
        chk("consumed", consumed, exp_consumed);
        chk("we_left", exp_we_a.size(), 0);
        chk("oe_left", exp_oe_a.size(), 0);
        chk("erase_left", exp_er_a.size(), 0);
      end
      if (src.size() > 0 && !(gap && cyc[0])) begin
        bus.s_valid = 1'b1;
        bus.s_data = src[0];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data = 8'hEE;
      end
      if (bus.s_valid && bus.s_ready) begin
        void'(src.pop_front());
        consumed++;
      end
    end
  end

  // Expected ops straight from the job description and the injected fault.
  task automatic plan(input logic [AW-1:0] sa, input int len, input bit er);
    logic [AW-1:0] a;
    exp_we_a.delete(); exp_we_d.delete(); exp_oe_a.delete(); exp_er_a.delete();
    exp_fail = 1'b0; exp_fail_addr = '0; exp_consumed = 0;
    if (len == 0) return;
    if (er) begin
      exp_er_a.push_back(sa);
      if (hang || eerr) begin
        exp_fail = 1'b1; exp_fail_addr = sa;
        return;
      end
    end
    for (int i = 0; i < len; i++) begin
      a = sa + AW'(i);
      exp_we_a.push_back(a);
      exp_we_d.push_back(jb[i]);
      exp_consumed = i + 1;
      if (hang) begin
        exp_fail = 1'b1; exp_fail_addr = a;
        return;
      end
      exp_oe_a.push_back(a);
      if (i == corrupt) begin
        exp_fail = 1'b1; exp_fail_addr = a;
        return;
      end
    end
  endtask

  task automatic start_job(input logic [AW-1:0] sa, input int len, input bit er,
                           input int corrupt_i, input bit hang_i, input bit eerr_i);
    corrupt = corrupt_i; hang = hang_i; eerr = eerr_i; rd_idx = 0;
    plan(sa, len, er);
    src = jb; consumed = 0;
    n_we = 0; n_oe = 0; n_er = 0; n_sready = 0;
    job_active = 1'b1;
    start_addr = sa; length = (AW + 1)'(len); do_erase = er; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done();
    int prev;
    prev = n_done;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (n_done != prev) break;
    end
    chk("done_seen", n_done - prev, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_fail"}, fail, 1'b0);
    chk({tag, "_fail_addr"}, fail_addr, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
    chk({tag, "_req"}, {bus.fc_we, bus.fc_oe, bus.fc_erase}, 0);
    chk({tag, "_address"}, bus.fc_address, 0);
    chk({tag, "_data"}, bus.fc_data_for_flash, 0);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk); #1;

    // 1: three bytes with verify, stream has bubbles
    gap = 1'b1;
    jb = '{8'hA5, 8'h5A, 8'hFF};
    start_job(22'h000010, 3, 1'b0, -1, 1'b0, 1'b0);
    wait_done();
    gap = 1'b0;
    chk("s1_we_count", n_we, 3);
    chk("s1_oe_count", n_oe, 3);
    chk("s1_last_we_addr", last_we_addr, 22'h000012);
    chk("s1_fail", fail, 1'b0);

    // 2: zero length with erase requested
    jb = '{8'h77};
    start_job(22'h000055, 0, 1'b1, -1, 1'b0, 1'b0);
    wait_done();
    chk("s2_done_latency", done_cyc - start_cyc, 2);
    chk("s2_no_ops", n_we + n_oe + n_er, 0);
    chk("s2_s_ready_never", n_sready, 0);

    // 3: erase then writes wrapping past the top address
    jb = '{8'h3C, 8'hC3};
    start_job(22'h3FFFFF, 2, 1'b1, -1, 1'b0, 1'b0);
    wait_done();
    chk("s3_erase_addr", first_er_addr, 22'h3FFFFF);
    chk("s3_erase_first", er_cyc < first_we_cyc, 1'b1);
    chk("s3_wrap_addr", last_we_addr, 22'h000000);
    chk("s3_we_count", n_we, 2);

    // 4: read-back of byte 2 returns 0x00
    jb = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_job(22'h000200, 4, 1'b0, 1, 1'b0, 1'b0);
    wait_done();
    chk("s4_fail", fail, 1'b1);
    chk("s4_fail_addr", fail_addr, 22'h000201);
    chk("s4_consumed", consumed, 2);

    // erase reports an error: nothing is written
    jb = '{8'h01, 8'h02};
    start_job(22'h002000, 2, 1'b1, -1, 1'b0, 1'b1);
    wait_done();
    chk("err_fail_addr", fail_addr, 22'h002000);
    chk("err_no_writes", n_we, 0);

    // 5: controller never returns ready
    jb = '{8'h99, 8'h98};
    start_job(22'h000040, 2, 1'b0, -1, 1'b1, 1'b0);
    wait_done();
    chk("s5_fail", fail, 1'b1);
    chk("s5_done_after_we", done_cyc - we_cyc, TMO + 2);

    // 6: reset in W_WAIT, then a clean job that ignores a mid-job start
    hang = 1'b0; eerr = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    jb = '{8'hA5, 8'h5A, 8'hFF};
    start_job(22'h000010, 3, 1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (n_we > 0) break;
    end
    chk("s6_we_seen", n_we > 0, 1'b1);
    nd = n_done;
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("midjob");
    rst = 1'b0;
    job_active = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("s6_no_done_on_reset", n_done, nd);
    start_job(22'h000010, 3, 1'b0, -1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    start_addr = 22'h000100; length = 23'd5; do_erase = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("s6_we_count", n_we, 3);
    chk("s6_erase_count", n_er, 0);
    chk("s6_last_we_addr", last_we_addr, 22'h000012);
    chk("s6_fail", fail, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
